// File: rtl/common.sv
// ---------------------------------------------------------------------------
// common: shared types and helpers for the M-extension multiply/divide unit.
//   XLEN / WLEN   : full datapath width and the width of the *W op forms
//   word_t        : one XLEN-bit datapath word
//   muldiv_op_t   : 4-bit operation code presented by execute
//   muldiv_state_t: sequencer states of muldiv_unit
//   is_w / is_mul : op classification helpers
//   sext_w        : sign-extend a 32-bit value to a full word
// ---------------------------------------------------------------------------
package common;

    localparam int XLEN = 64;
    localparam int WLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        MUL    = 4'd0,
        MULH   = 4'd1,
        MULHSU = 4'd2,
        MULHU  = 4'd3,
        DIV    = 4'd4,
        DIVU   = 4'd5,
        REM    = 4'd6,
        REMU   = 4'd7,
        MULW   = 4'd8,
        DIVW   = 4'd9,
        DIVUW  = 4'd10,
        REMW   = 4'd11,
        REMUW  = 4'd12
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_w(input muldiv_op_t op);
        return (op == MULW) || (op == DIVW) || (op == DIVUW) ||
               (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic is_mul(input muldiv_op_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) ||
               (op == MULHU) || (op == MULW);
    endfunction

    function automatic word_t sext_w(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/pipes.sv
// ---------------------------------------------------------------------------
// pipes: pipeline control bundle carried from decode into execute.
//   control_t.muldiv marks an M-extension op that execute hands to
//   muldiv_unit instead of the ALU.
// ---------------------------------------------------------------------------
package pipes;

    typedef struct packed {
        logic alu;
        logic muldiv;
        logic memRead;
        logic memWrite;
        logic regWrite;
    } control_t;

endpackage

// File: rtl/muldiv_prep.sv
// ---------------------------------------------------------------------------
// muldiv_prep: combinational operand preparation for muldiv_unit.
//   op_i             : normalised operation code
//   src1_i, src2_i   : raw operands from execute
//   magA_o, magB_o   : operand magnitudes (W ops narrowed to 32 bits first)
//   negRes_o         : product / quotient must be negated at the end
//   negRem_o         : remainder must be negated (follows dividend sign)
//   special_o        : divide that resolves without iterating
//   specialResult_o  : result for the special case
// ---------------------------------------------------------------------------
module muldiv_prep
    import common::*;
(
    input  muldiv_op_t      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic [XLEN-1:0] magA_o,
    output logic [XLEN-1:0] magB_o,
    output logic            negRes_o,
    output logic            negRem_o,
    output logic            special_o,
    output logic [XLEN-1:0] specialResult_o
);

    logic  aSigned, bSigned, isW, isDiv, isRem;
    logic  negA, negB, divZero, overflow;
    word_t extA, extB, opA, opB;

    // Narrow W operands, take magnitudes of the signed ones and spot the
    // two divide cases (zero divisor, most-negative / -1) that skip the
    // iterative loop. The sign-extended dividend doubles as the
    // special-case remainder and overflow quotient, even for the unsigned
    // W forms, because every W result is sign-extended from bit 31.
    always_comb begin
        aSigned = op_i inside {MUL, MULH, MULHSU, DIV, REM, MULW, DIVW, REMW};
        bSigned = op_i inside {MUL, MULH, DIV, REM, MULW, DIVW, REMW};
        isW     = is_w(op_i);
        isDiv   = !is_mul(op_i);
        isRem   = op_i inside {REM, REMU, REMW, REMUW};

        extA = isW ? sext_w(src1_i[WLEN-1:0]) : src1_i;
        extB = isW ? sext_w(src2_i[WLEN-1:0]) : src2_i;
        opA  = (isW && !aSigned) ? {{(XLEN-WLEN){1'b0}}, src1_i[WLEN-1:0]} : extA;
        opB  = (isW && !bSigned) ? {{(XLEN-WLEN){1'b0}}, src2_i[WLEN-1:0]} : extB;

        negA   = aSigned && opA[XLEN-1];
        negB   = bSigned && opB[XLEN-1];
        magA_o = negA ? -opA : opA;
        magB_o = negB ? -opB : opB;

        negRes_o = negA ^ negB;
        negRem_o = negA;

        divZero  = (opB == '0);
        overflow = aSigned && (opB == '1) &&
                   (isW ? (src1_i[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}})
                        : (src1_i == {1'b1, {(XLEN-1){1'b0}}}));

        special_o       = isDiv && (divZero || overflow);
        specialResult_o = '0;
        if (divZero) begin
            specialResult_o = isRem ? extA : '1;
        end else if (overflow) begin
            specialResult_o = isRem ? '0 : extA;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit: iterative RV64M multiply/divide beside the execute ALU.
//   clk, reset     : clock, synchronous active-high reset
//   valid, op      : execute presents an M-extension op (op codes from common)
//   src1, src2     : forwarded operands
//   flush          : abort whatever is in flight
//   ack            : pipeline consumed the result
//   ready          : idle, can accept
//   stall          : execute must hold its op
//   done, result   : result valid / value (held until ack)
// Multiply is radix-2 shift-add into {acc,lo}; divide is restoring with the
// remainder in acc and the quotient shifting into lo.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    input  logic            ack,
    output logic            ready,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import common::*;

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      opNorm, op_q, op_d;
    logic [6:0]      count_q, count_d;
    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, mag_q, mag_d, result_q, result_d;
    logic            negRes_q, negRes_d, negRem_q, negRem_d;

    logic [XLEN-1:0] prepMagA, prepMagB, prepSpecialResult;
    logic            prepNegRes, prepNegRem, prepSpecial;

    logic [XLEN:0]     mulSum, divShift, divTrial;
    logic [XLEN-1:0]   stepAcc, stepLo, quot, remd, finalResult;
    logic [2*XLEN-1:0] prodMag, prodSigned;

    // Codes beyond the defined set are executed as a plain mul.
    always_comb begin
        opNorm = (op > 4'd12) ? MUL : muldiv_op_t'(op);
    end

    muldiv_prep prep (
        .op_i            (opNorm),
        .src1_i          (src1),
        .src2_i          (src2),
        .magA_o          (prepMagA),
        .magB_o          (prepMagB),
        .negRes_o        (prepNegRes),
        .negRem_o        (prepNegRem),
        .special_o       (prepSpecial),
        .specialResult_o (prepSpecialResult)
    );

    // One iteration of whichever algorithm is in flight. Multiply adds the
    // multiplicand when the multiplier LSB is set and shifts {acc,lo} right;
    // divide shifts {acc,lo} left and keeps the trial subtraction when it
    // does not go negative.
    always_comb begin
        mulSum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        divShift = {acc_q, lo_q[XLEN-1]};
        divTrial = divShift - {1'b0, mag_q};
        if (is_mul(op_q)) begin
            stepAcc = mulSum[XLEN:1];
            stepLo  = {mulSum[0], lo_q[XLEN-1:1]};
        end else if (!divTrial[XLEN]) begin
            stepAcc = divTrial[XLEN-1:0];
            stepLo  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            stepAcc = divShift[XLEN-1:0];
            stepLo  = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up applied on the last iteration. A W multiply only runs 32
    // steps, so its product sits 32 bits higher in {acc,lo}.
    always_comb begin
        prodMag    = is_w(op_q) ? ({stepAcc, stepLo} >> WLEN) : {stepAcc, stepLo};
        prodSigned = negRes_q ? -prodMag : prodMag;
        quot       = negRes_q ? -stepLo : stepLo;
        remd       = negRem_q ? -stepAcc : stepAcc;
        case (op_q)
            MULH, MULHSU, MULHU: finalResult = prodSigned[2*XLEN-1:XLEN];
            MULW:                finalResult = sext_w(prodSigned[WLEN-1:0]);
            DIV, DIVU:           finalResult = quot;
            REM, REMU:           finalResult = remd;
            DIVW, DIVUW:         finalResult = sext_w(quot[WLEN-1:0]);
            REMW, REMUW:         finalResult = sext_w(remd[WLEN-1:0]);
            default:             finalResult = prodSigned[XLEN-1:0];
        endcase
    end

    // Sequencer next state. Flush wins everywhere and leaves result alone.
    // W divides preload the dividend into the top half of lo so the 32
    // iterations consume its bits MSB first.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        mag_d    = mag_q;
        result_d = result_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    op_d     = opNorm;
                    negRes_d = prepNegRes;
                    negRem_d = prepNegRem;
                    if (prepSpecial) begin
                        result_d = prepSpecialResult;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                        count_d = is_w(opNorm) ? 7'd32 : 7'd64;
                        acc_d   = '0;
                        if (is_mul(opNorm)) begin
                            mag_d = prepMagA;
                            lo_d  = prepMagB;
                        end else begin
                            mag_d = prepMagB;
                            lo_d  = is_w(opNorm) ? (prepMagA << WLEN) : prepMagA;
                        end
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = stepAcc;
                    lo_d    = stepLo;
                    count_d = count_q - 7'd1;
                    if (count_q == 7'd1) begin
                        result_d = finalResult;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and work registers; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            count_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            mag_q    <= '0;
            result_q <= '0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign stall  = valid && (state_q != DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit. The driver
// pushes the hand-computed result and the cycle at which done must first
// appear; an independent monitor pops and compares whenever done rises.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    import common::*;

    logic        clk, reset, valid, flush, ack;
    logic [3:0]  op;
    logic [63:0] src1, src2, result;
    logic        ready, stall, done;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int lastAccept = 0;

    logic [63:0] expRes[$];
    int          expCyc[$];
    string       expName[$];

    logic [63:0] monRes;
    int          monCyc;
    string       monName;
    bit          doneSeen = 0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .flush  (flush),
        .ack    (ack),
        .ready  (ready),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard pop per rising done, checking value and timing.
    always @(negedge clk) begin
        if (done && !doneSeen) begin
            doneSeen = 1'b1;
            if (expRes.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected done: result %h with nothing expected", result);
            end else begin
                monRes  = expRes.pop_front();
                monCyc  = expCyc.pop_front();
                monName = expName.pop_front();
                checkOutput({monName, " result"}, result, monRes);
                checkOutput({monName, " latency"}, 64'(cycle), 64'(monCyc));
            end
        end else if (!done) begin
            doneSeen = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    // with valid still asserted.
    task automatic issueOp(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        int guard = 0;
        while (!ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) checkOutput("ready wait", 64'(ready), 64'd1);
        valid = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        lastAccept = cycle;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] exp, input int lat, input string name,
                                 input int hold);
        int guard = 0;
        bit stallOk = 1'b1;
        issueOp(o, a, b);
        expRes.push_back(exp);
        expCyc.push_back(lastAccept + lat);
        expName.push_back(name);
        while (!done && guard < 300) begin
            if (stall !== 1'b1) stallOk = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (lat > 0) checkOutput({name, " stall while busy"}, 64'(stallOk), 64'd1);
        checkOutput({name, " done seen"}, 64'(done), 64'd1);
        checkOutput({name, " stall in done"}, 64'(stall), 64'd0);
        checkOutput({name, " ready in done"}, 64'(ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({name, " held result"}, result, exp);
            checkOutput({name, " held done"}, 64'(done), 64'd1);
            checkOutput({name, " held stall"}, 64'(stall), 64'd0);
            checkOutput({name, " held ready"}, 64'(ready), 64'd0);
        end
        // With a hold, valid stays up through the ack cycle: it must not
        // start a new op there.
        valid = (hold > 0);
        ack   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        ack   = 1'b0;
        checkOutput({name, " ready after ack"}, 64'(ready), 64'd1);
        checkOutput({name, " done after ack"}, 64'(done), 64'd0);
    endtask

    task automatic abortOp(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                           input bit useReset, input string name);
        issueOp(o, a, b);
        repeat (9) @(negedge clk);
        checkOutput({name, " busy before abort"}, 64'(ready), 64'd0);
        valid = 1'b0;
        if (useReset) reset = 1'b1;
        else          flush = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        checkOutput({name, " ready after abort"}, 64'(ready), 64'd1);
        checkOutput({name, " done after abort"}, 64'(done), 64'd0);
        if (useReset) checkOutput({name, " result cleared"}, result, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        ack   = 1'b0;
        op    = 4'd0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset ready", 64'(ready), 64'd1);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset stall", 64'(stall), 64'd0);
        checkOutput("reset result", result, 64'd0);

        applyStimulus(MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, "mul 7*-3", 0);
        applyStimulus(DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, "div -7/2", 0);
        applyStimulus(REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, "rem -7/2", 0);
        applyStimulus(REMU,   64'd7, 64'd2, 64'd1, 64, "remu 7/2", 0);
        applyStimulus(DIVU,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divu 5/0", 0);
        applyStimulus(REM,    64'd5, 64'd0, 64'd5, 0, "rem 5/0", 0);
        applyStimulus(DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h8000_0000_0000_0000, 0, "div ovf", 0);
        applyStimulus(REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, "rem ovf", 0);
        applyStimulus(MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFE, 64, "mulhu max", 0);
        applyStimulus(MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64, "mulh -1*-1", 0);
        applyStimulus(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, "mulhsu -1*2", 0);
        applyStimulus(MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, "mulw", 0);
        applyStimulus(DIVUW,  64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32, "divuw", 0);
        applyStimulus(REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, "remw -7/2", 0);
        applyStimulus(DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                              64'hFFFF_FFFF_8000_0000, 0, "divw ovf", 0);
        applyStimulus(REMUW,  64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0000,
                              64'hFFFF_FFFF_FFFF_FFF9, 0, "remuw by 0", 0);
        applyStimulus(4'd15,  64'd6, 64'd7, 64'd42, 64, "unknown op as mul", 0);

        abortOp(DIVU, 64'd1000, 64'd3, 1'b0, "flush busy");
        // flush together with valid in idle must not accept
        valid = 1'b1;
        flush = 1'b1;
        op    = DIVU;
        src1  = 64'd9;
        src2  = 64'd3;
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        checkOutput("flush blocks accept", 64'(ready), 64'd1);
        applyStimulus(DIVU, 64'd100, 64'd7, 64'd14, 64, "divu after flush", 0);

        abortOp(MUL, 64'd5, 64'd5, 1'b1, "reset busy");
        applyStimulus(DIVU, 64'd100, 64'd7, 64'd14, 64, "divu after reset", 0);

        applyStimulus(MUL, 64'd3, 64'd4, 64'd12, 64, "mul held done", 5);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", 64'(expRes.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
